i2c_txn_sched: RTL and testbench
================================

Name: i2c_txn_sched

Overview:
- Transaction scheduler in front of the shared I2C byte engine (the START/8-bit/ACK/STOP sequencer driving sda_w/ctrl_h).
- Arbitrates NREQ requesters (e.g. command-list path and pixel-stream path) round-robin.
- Frames each grant as one I2C write: slave address, control byte, then LEN data bytes.
- Streams data bytes from the granted requester; retries header NACKs; reports done/err per requester.

Parameters:
NREQ, 2, number of requesters (2..4)
SLV_ADDR, 8'h78, 8-bit write address sent as first byte
MAX_RETRY, 3, header (address/control) NACK retries before error

Ports:
clk2  in  1  state clock
reset  in  1  asynchronous, active-low reset
req  in  NREQ  transaction request per requester, level, held until done/err
req_ctrl  in  8*NREQ  control byte per requester (e.g. 8'h00 cmd, 8'hC0 data)
req_len  in  8*NREQ  data byte count per requester, 0..255
data_in  in  8  next data byte from granted requester (valid while gnt)
data_rd  out  1  pulse: data_in consumed, requester advances next cycle
gnt  out  NREQ  one-hot grant, high for whole transaction
done  out  NREQ  one-cycle pulse, transaction ACKed to the end
err  out  NREQ  one-cycle pulse, transaction aborted on NACK
busy  out  1  high when state != IDLE
eng_go  out  1  one-cycle pulse: engine sends eng_byte
eng_byte  out  8  byte to send
eng_first  out  1  qualifies eng_go: prefix START
eng_last  out  1  qualifies eng_go: append STOP after ACK
eng_busy  in  1  engine mid-byte; eng_go never issued while high
eng_done  in  1  one-cycle pulse: byte finished
eng_nack  in  1  valid with eng_done: 1 = NACK; engine issues STOP itself on NACK

Behaviour:
- Reset (async, reset=0): state IDLE; rr pointer 0; all outputs 0; retry and byte counters 0; latched ctrl/len 0. Reset mid-transaction abandons it silently (no done/err).
- States: IDLE, SEND, WAIT, FIN.
- IDLE: if any req bit set, pick first set bit searching from rr pointer upward with wrap. Latch that requester's req_ctrl and req_len. Clear retry count. Set phase=ADDR. Register gnt one-hot. Next state SEND. Request seen at edge N gives gnt high after edge N.
- SEND: eng_go = !eng_busy, combinational. eng_byte by phase: ADDR gives SLV_ADDR, CTRL gives latched ctrl, DATA gives data_in. eng_first=1 only in ADDR. eng_last=1 on CTRL when len==0, or on DATA when remaining count==1. data_rd = eng_go in DATA phase. Advances to WAIT on the edge where eng_go=1.
- WAIT: hold outputs except eng_go/data_rd (0). Ignore all inputs until eng_done.
  - eng_done with eng_nack=0 and the last byte sent: go to FIN.
  - eng_done with eng_nack=0 otherwise: ADDR goes to CTRL; CTRL goes to DATA with remaining=len; DATA decrements remaining. Then back to SEND.
  - eng_done with eng_nack=1, phase ADDR or CTRL, retry<MAX_RETRY: retry+1, phase=ADDR, back to SEND. No data was consumed, so the replay is safe.
  - eng_done with eng_nack=1 in DATA phase, or retries exhausted: pulse err[granted], clear gnt, advance rr, go to IDLE.
- FIN: pulse done[granted] for one cycle, clear gnt, rr pointer = granted+1 mod NREQ, go to IDLE. A new grant may occur on the next cycle.
- Requester dropping req mid-transaction is ignored; the transaction runs to completion.
- eng_done outside WAIT is ignored.
- Exactly one of done/err pulses per grant.
- At most one gnt bit high at any time; gnt never changes outside IDLE/FIN/abort.
- Byte count per transaction: 2+len on success. len=0 sends header only, with STOP after the control byte.

Test Plan:
- Single req[0], ctrl=8'h00, len=2, data 8'hAE,8'hAF, engine always ACK -> eng_byte sequence 78,00,AE,AF; eng_first on 78 only; eng_last on AF only; 2 data_rd pulses; done[0] once; gnt[0] high throughout.
- req=2'b11 held continuously, len=1 each -> grants alternate 0,1,0,1; done pulses alternate; never two gnt bits high.
- NACK on address byte twice, then ACK, len=0 -> 78 sent 3 times with eng_first each; then C0 with eng_last; done pulse; no err.
- NACK on address 4 times (MAX_RETRY=3) -> exactly 4 address attempts; err[0] pulse; zero data_rd; gnt drops; rr advances.
- NACK on 2nd of 3 data bytes -> err pulse; exactly 2 data_rd; no retry.
- eng_busy held high 5 cycles in SEND -> eng_go deferred until busy drops. Separately, reset asserted in WAIT -> all outputs 0 immediately; after release, pending req is re-granted from rr=0.

Source files
------------

// File: rtl/i2c_txn_sched.sv
// Round-robin transaction scheduler in front of the shared I2C byte engine.
// Frames each grant as address, control byte and LEN data bytes; replays NACKed headers.
module i2c_txn_sched #(
    parameter int unsigned NREQ      = 2,
    parameter logic [7:0]  SLV_ADDR  = 8'h78,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              clk2,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_ctrl,
    input  logic [8*NREQ-1:0] req_len,
    input  logic [7:0]        data_in,
    output logic              data_rd,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic              busy,
    output logic              eng_go,
    output logic [7:0]        eng_byte,
    output logic              eng_first,
    output logic              eng_last,
    input  logic              eng_busy,
    input  logic              eng_done,
    input  logic              eng_nack
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_FIN} state_e;
    typedef enum logic [1:0] {PH_ADDR, PH_CTRL, PH_DATA} phase_e;

    state_e          state_q, state_d;
    phase_e          phase_q, phase_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [7:0]      ctrl_q, ctrl_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      rem_q, rem_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [7:0]      byte_q, byte_d;

    logic [7:0]      ctrl_a [NREQ];
    logic [7:0]      len_a  [NREQ];
    logic            arb_hit;
    logic [IW-1:0]   arb_idx;
    int unsigned     arb_k;
    logic [IW-1:0]   rr_next;
    logic            last_c;
    logic [7:0]      send_byte;

    for (genvar g = 0; g < NREQ; g++) begin : g_split
        assign ctrl_a[g] = req_ctrl[8*g +: 8];
        assign len_a[g]  = req_len[8*g +: 8];
    end

    // First requesting index at or above the round-robin pointer, with wrap.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        arb_k   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            arb_k = 32'(rr_q) + i;
            if (arb_k >= NREQ) begin
                arb_k = arb_k - NREQ;
            end
            if (!arb_hit && req[IW'(arb_k)]) begin
                arb_hit = 1'b1;
                arb_idx = IW'(arb_k);
            end
        end
    end

    assign rr_next = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
    assign last_c  = ((phase_q == PH_CTRL) && (len_q == 8'd0)) ||
                     ((phase_q == PH_DATA) && (rem_q == 8'd1));

    always_comb begin
        case (phase_q)
            PH_CTRL: send_byte = ctrl_q;
            PH_DATA: send_byte = data_in;
            default: send_byte = SLV_ADDR;
        endcase
    end

    // Engine handshake; the byte is frozen in WAIT because the requester may advance.
    assign eng_go    = (state_q == S_SEND) && !eng_busy;
    assign data_rd   = eng_go && (phase_q == PH_DATA);
    assign eng_byte  = (state_q == S_SEND) ? send_byte :
                       (state_q == S_WAIT) ? byte_q : 8'h00;
    assign eng_first = ((state_q == S_SEND) || (state_q == S_WAIT)) && (phase_q == PH_ADDR);
    assign eng_last  = ((state_q == S_SEND) || (state_q == S_WAIT)) && last_c;
    assign busy      = (state_q != S_IDLE);
    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        ctrl_d  = ctrl_q;
        len_d   = len_q;
        rem_d   = rem_q;
        retry_d = retry_q;
        byte_d  = byte_q;
        case (state_q)
            S_IDLE: begin
                if (arb_hit) begin
                    gidx_d          = arb_idx;
                    gnt_d           = '0;
                    gnt_d[arb_idx]  = 1'b1;
                    ctrl_d          = ctrl_a[arb_idx];
                    len_d           = len_a[arb_idx];
                    retry_d         = '0;
                    phase_d         = PH_ADDR;
                    state_d         = S_SEND;
                end
            end
            S_SEND: begin
                if (eng_go) begin
                    byte_d  = send_byte;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_done) begin
                    if (!eng_nack) begin
                        if (last_c) begin
                            state_d = S_FIN;
                        end else begin
                            state_d = S_SEND;
                            case (phase_q)
                                PH_ADDR: phase_d = PH_CTRL;
                                PH_CTRL: begin
                                    phase_d = PH_DATA;
                                    rem_d   = len_q;
                                end
                                default: rem_d = rem_q - 8'd1;
                            endcase
                        end
                    end else if ((phase_q != PH_DATA) && (retry_q < RW'(MAX_RETRY))) begin
                        // No data consumed yet, so replaying the header is safe.
                        retry_d = retry_q + RW'(1);
                        phase_d = PH_ADDR;
                        state_d = S_SEND;
                    end else begin
                        err_d   = gnt_q;
                        gnt_d   = '0;
                        rr_d    = rr_next;
                        state_d = S_IDLE;
                    end
                end
            end
            S_FIN: begin
                done_d  = gnt_q;
                gnt_d   = '0;
                rr_d    = rr_next;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            phase_q <= PH_ADDR;
            rr_q    <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            ctrl_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            retry_q <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ctrl_q  <= ctrl_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            retry_q <= retry_d;
            byte_q  <= byte_d;
        end
    end

endmodule

// File: tb/tb_i2c_txn_sched.sv
// Scoreboard bench for i2c_txn_sched: a transaction-level model predicts grant order,
// engine bytes and outcomes; an engine model replies ACK/NACK, a monitor compares.
module tb_i2c_txn_sched;

    localparam int MAXR = 3;

    logic        clk2;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_ctrl;
    logic [15:0] req_len;
    logic [7:0]  data_in;
    logic        data_rd;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        busy;
    logic        eng_go;
    logic [7:0]  eng_byte;
    logic        eng_first;
    logic        eng_last;
    logic        eng_busy;
    logic        eng_done;
    logic        eng_nack;

    i2c_txn_sched #(.NREQ(2), .SLV_ADDR(8'h78), .MAX_RETRY(3)) dut (
        .clk2(clk2), .reset(reset), .req(req), .req_ctrl(req_ctrl), .req_len(req_len),
        .data_in(data_in), .data_rd(data_rd), .gnt(gnt), .done(done), .err(err),
        .busy(busy), .eng_go(eng_go), .eng_byte(eng_byte), .eng_first(eng_first),
        .eng_last(eng_last), .eng_busy(eng_busy), .eng_done(eng_done), .eng_nack(eng_nack)
    );

    typedef struct { logic [7:0] b; logic first; logic last; logic isd; int r; } exp_t;
    typedef struct { int r; logic is_err; } out_t;

    exp_t eq[$];
    bit   rq[$];
    out_t oq[$];

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int go_cnt = 0;
    logic eng_en;
    logic mon_en;
    int xb_force;
    int m_rr;
    int round_id = 0;
    int drop_id[2] = '{-1, -1};
    logic [1:0] want;
    logic [7:0] dbuf [2][256];
    int ptr[2] = '{0, 0};
    logic [7:0] c_ctrl[2];
    int c_len[2];
    int c_na[2];
    int c_dn[2];

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    always_comb begin
        for (int i = 0; i < 2; i++) req[i] = want[i] && (drop_id[i] != round_id);
    end

    always_comb begin
        data_in = 8'h00;
        for (int i = 0; i < 2; i++) if (gnt[i]) data_in = dbuf[i][ptr[i] & 255];
    end

    // Requester side: read pointer restarts with each new grant.
    always @(posedge clk2) begin
        for (int i = 0; i < 2; i++) begin
            if (!gnt[i]) ptr[i] <= 0;
            else if (data_rd) ptr[i] <= ptr[i] + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model of one granted transaction.
    function automatic void model_txn(input int r);
        exp_t e;
        out_t o;
        int a;
        o.r = r;
        a = 0;
        forever begin
            e.b = 8'h78; e.first = 1'b1; e.last = 1'b0; e.isd = 1'b0; e.r = r;
            eq.push_back(e);
            rq.push_back(a < c_na[r]);
            if (a >= c_na[r]) break;
            if (a == MAXR) begin
                o.is_err = 1'b1;
                oq.push_back(o);
                return;
            end
            a++;
        end
        e.b = c_ctrl[r]; e.first = 1'b0; e.last = (c_len[r] == 0); e.isd = 1'b0;
        eq.push_back(e);
        rq.push_back(1'b0);
        for (int j = 0; j < c_len[r]; j++) begin
            e.b = dbuf[r][j]; e.first = 1'b0; e.last = (j == c_len[r] - 1); e.isd = 1'b1;
            eq.push_back(e);
            rq.push_back(j == c_dn[r]);
            if (j == c_dn[r]) begin
                o.is_err = 1'b1;
                oq.push_back(o);
                return;
            end
        end
        o.is_err = 1'b0;
        oq.push_back(o);
    endfunction

    task automatic set_cfg(input int r, input logic [7:0] ctrl, input int len, input int na, input int dn);
        c_ctrl[r] = ctrl; c_len[r] = len; c_na[r] = na; c_dn[r] = dn;
        for (int j = 0; j < 256; j++) dbuf[r][j] = 8'($urandom_range(0, 255));
    endtask

    task automatic do_round(input logic [1:0] sub);
        int rr;
        int c;
        int cyc;
        logic [1:0] pend;
        @(negedge clk2);
        rr = m_rr;
        pend = sub;
        while (pend != 2'b00) begin
            c = -1;
            for (int k = 0; k < 2; k++) begin
                if (c < 0 && pend[(rr + k) % 2]) c = (rr + k) % 2;
            end
            model_txn(c);
            pend[c] = 1'b0;
            rr = (c + 1) % 2;
        end
        m_rr = rr;
        req_ctrl = {c_ctrl[1], c_ctrl[0]};
        req_len  = {8'(c_len[1]), 8'(c_len[0])};
        round_id++;
        want = sub;
        cyc = 0;
        while ((oq.size() != 0 || req != 2'b00) && cyc < 3000) begin
            @(posedge clk2);
            cyc++;
        end
        chk("round_timeout", 32'(cyc >= 3000), 32'(0));
        want = 2'b00;
        repeat (3) @(posedge clk2);
        #1;
        chk("busy_idle", 32'(busy), 32'(0));
        chk("gnt_idle", 32'(gnt), 32'(0));
    endtask

    // Byte engine model: ACK/NACK from the model's reply queue, random latency and trailing busy.
    initial begin
        bit nk;
        int lat;
        int xb;
        eng_busy = 1'b0; eng_done = 1'b0; eng_nack = 1'b0;
        forever begin
            @(negedge clk2);
            if (eng_en && eng_go) begin
                nk = (rq.size() > 0) ? rq.pop_front() : 1'b0;
                lat = $urandom_range(0, 2);
                xb = (xb_force >= 0) ? xb_force : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
                @(posedge clk2); #1;
                eng_busy = 1'b1;
                repeat (lat) begin @(posedge clk2); #1; end
                eng_done = 1'b1; eng_nack = nk;
                @(posedge clk2); #1;
                eng_done = 1'b0; eng_nack = 1'b0;
                repeat (xb) begin @(posedge clk2); #1; end
                eng_busy = 1'b0;
            end else if (eng_en && !eng_go && $urandom_range(0, 19) == 0) begin
                // Stray completion outside WAIT must be ignored.
                @(posedge clk2); #1;
                eng_busy = 1'b1; eng_done = 1'b1; eng_nack = 1'($urandom_range(0, 1));
                @(posedge clk2); #1;
                eng_busy = 1'b0; eng_done = 1'b0; eng_nack = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        out_t o;
        forever begin
            @(negedge clk2);
            for (int i = 0; i < 2; i++) if (done[i] || err[i]) drop_id[i] = round_id;
            if (data_rd) rd_cnt++;
            if (mon_en) begin
                chk("gnt_onehot", 32'($onehot0(gnt)), 32'(1));
                chk("go_while_busy", 32'(eng_go && eng_busy), 32'(0));
                chk("rd_without_go", 32'(data_rd && !eng_go), 32'(0));
                if (eng_go) begin
                    go_cnt++;
                    if (eq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_go: got byte %0h expected none", eng_byte);
                    end else begin
                        e = eq.pop_front();
                        chk("eng_byte", 32'(eng_byte), 32'(e.b));
                        chk("eng_first", 32'(eng_first), 32'(e.first));
                        chk("eng_last", 32'(eng_last), 32'(e.last));
                        chk("data_rd", 32'(data_rd), 32'(e.isd));
                        chk("gnt_on_go", 32'(gnt), 32'(1 << e.r));
                        chk("busy_on_go", 32'(busy), 32'(1));
                    end
                end
                if (done != 2'b00 || err != 2'b00) begin
                    if (oq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_outcome: got done=%0b err=%0b expected none", done, err);
                    end else begin
                        o = oq.pop_front();
                        chk("done", 32'(done), o.is_err ? 32'(0) : 32'(1 << o.r));
                        chk("err", 32'(err), o.is_err ? 32'(1 << o.r) : 32'(0));
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int go0;
        int cyc;
        int sel;
        logic [1:0] sub;
        reset = 1'b0; want = 2'b00; req_ctrl = '0; req_len = '0;
        eng_en = 1'b1; mon_en = 1'b1; xb_force = -1; m_rr = 0;
        for (int r = 0; r < 2; r++) set_cfg(r, 8'h00, 0, 0, -1);
        repeat (3) @(posedge clk2);
        #1;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_go", 32'(eng_go), 32'(0));
        chk("rst_byte", 32'({eng_byte, eng_first, eng_last, data_rd, done, err}), 32'(0));
        @(negedge clk2);
        reset = 1'b1;

        set_cfg(0, 8'h00, 2, 0, -1);
        dbuf[0][0] = 8'hAE; dbuf[0][1] = 8'hAF;
        rd0 = rd_cnt;
        do_round(2'b01);
        chk("t1_rd_count", 32'(rd_cnt - rd0), 32'(2));

        for (int k = 0; k < 2; k++) begin
            set_cfg(0, 8'h00, 1, 0, -1);
            set_cfg(1, 8'hC0, 1, 0, -1);
            do_round(2'b11);
        end

        set_cfg(0, 8'hC0, 0, 2, -1);
        go0 = go_cnt;
        do_round(2'b01);
        chk("t3_go_count", 32'(go_cnt - go0), 32'(4));

        set_cfg(0, 8'h00, 2, 4, -1);
        rd0 = rd_cnt; go0 = go_cnt;
        do_round(2'b01);
        chk("t4_rd_count", 32'(rd_cnt - rd0), 32'(0));
        chk("t4_go_count", 32'(go_cnt - go0), 32'(4));
        set_cfg(0, 8'h00, 1, 0, -1);
        set_cfg(1, 8'hC0, 1, 0, -1);
        do_round(2'b11);

        set_cfg(1, 8'hC0, 3, 0, 1);
        rd0 = rd_cnt;
        do_round(2'b10);
        chk("t5_rd_count", 32'(rd_cnt - rd0), 32'(2));

        xb_force = 5;
        set_cfg(0, 8'h00, 2, 0, -1);
        do_round(2'b01);
        xb_force = -1;

        // Reset while waiting on the engine, with the pointer away from zero.
        set_cfg(0, 8'h00, 1, 0, -1);
        do_round(2'b01);
        repeat (2) @(posedge clk2);
        #1;
        eng_en = 1'b0;
        repeat (4) @(posedge clk2);
        @(negedge clk2);
        mon_en = 1'b0;
        req_ctrl = 16'hC000; req_len = 16'h0202;
        round_id++;
        want = 2'b11;
        cyc = 0;
        while (!eng_go && cyc < 20) begin @(negedge clk2); cyc++; end
        chk("rst_pre_go_seen", 32'(eng_go), 32'(1));
        chk("rst_pre_gnt", 32'(gnt), 32'(1 << m_rr));
        @(posedge clk2);
        repeat (2) @(posedge clk2);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_mid_gnt", 32'(gnt), 32'(0));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_go", 32'(eng_go), 32'(0));
        chk("rst_mid_misc", 32'({eng_byte, eng_first, eng_last, data_rd, done, err}), 32'(0));
        @(negedge clk2);
        reset = 1'b1;
        @(posedge clk2);
        #1;
        chk("rst_regrant", 32'(gnt), 32'(2'b01));
        @(negedge clk2);
        reset = 1'b0;
        want = 2'b00;
        @(negedge clk2);
        reset = 1'b1;
        m_rr = 0;
        @(posedge clk2);
        #1;
        eng_en = 1'b1;
        mon_en = 1'b1;

        for (int n = 0; n < 40; n++) begin
            sub = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                int len;
                int na;
                int dn;
                len = $urandom_range(0, 6);
                sel = $urandom_range(0, 9);
                na = (sel < 6) ? 0 : (sel < 8) ? 1 : (sel < 9) ? 2 : MAXR + 1;
                dn = (len > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
                set_cfg(r, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hC0, len, na, dn);
            end
            do_round(sub);
        end

        chk("eq_left", 32'(eq.size()), 32'(0));
        chk("rq_left", 32'(rq.size()), 32'(0));
        chk("oq_left", 32'(oq.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
